// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: command handshake, raw line levels and open-drain enables.
// master = command source / bus side, slave = ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] iData;
  logic       iSend;
  logic       iPS2_CLK;
  logic       iPS2_DATA;
  logic       oPS2_CLK_OE;
  logic       oPS2_DATA_OE;
  logic       oBusy;
  logic       oDone;
  logic       oError;

  modport master (
    output iData, iSend, iPS2_CLK, iPS2_DATA,
    input  oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError
  );

  modport slave (
    input  iData, iSend, iPS2_CLK, iPS2_DATA,
    output oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data bits, odd parity, stop, device ack.
// Define PS2_TX_TIMEOUT_EN to build the transfer watchdog (TIMEOUT_CYCLES).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic         Clock,
  input  logic         Reset,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(INHIBIT_CYCLES);
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned STOP_I = 9;

  // The data-OE lead cycle needs at least two inhibit cycles; the filter needs two taps.
  if (INHIBIT_CYCLES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES and FILTER_LEN must be >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  // ---------------------------------------------------------------------------
  // Line conditioning: 2-FF synchronizer, then a level that moves only on agreement
  // ---------------------------------------------------------------------------
  logic [1:0]            clk_sync_q;
  logic [1:0]            data_sync_q;
  logic [FILTER_LEN-1:0] clk_sh_q;
  logic [FILTER_LEN-1:0] data_sh_q;
  logic                  clk_filt_q;
  logic                  data_filt_q;
  logic                  clk_fall_c;

  always_ff @(posedge Clock or negedge Reset) begin : p_cond
    if (!Reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_sh_q    <= '1;
      data_sh_q   <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.iPS2_CLK};
      data_sync_q <= {data_sync_q[0], bus.iPS2_DATA};
      clk_sh_q    <= {clk_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
      data_sh_q   <= {data_sh_q[FILTER_LEN-2:0], data_sync_q[1]};
      if (&clk_sh_q) begin
        clk_filt_q <= 1'b1;
      end else if (~|clk_sh_q) begin
        clk_filt_q <= 1'b0;
      end
      if (&data_sh_q) begin
        data_filt_q <= 1'b1;
      end else if (~|data_sh_q) begin
        data_filt_q <= 1'b0;
      end
    end
  end

  // Filtered clock is about to drop: the host presents the next bit now.
  assign clk_fall_c = clk_filt_q & ~|clk_sh_q;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [8:0]       tx_q,      tx_d;
  logic             nack_q,    nack_d;
  logic             clk_oe_q,  clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             error_q,   error_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_run_c;
  logic            wd_expire_c;

  // Watchdog runs from DATA entry until the transfer ends.
  assign wd_run_c    = (state_q == S_DATA) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign wd_expire_c = wd_run_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_d        = wd_run_c ? (wd_q + WD_W'(1)) : '0;

  always_ff @(posedge Clock or negedge Reset) begin : p_wd
    if (!Reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_comb begin : p_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    nack_d    = nack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (bus.iSend) begin
          tx_d     = {~^bus.iData, bus.iData};
          idx_d    = '0;
          cnt_d    = '0;
          nack_d   = 1'b0;
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) begin
          data_oe_d = 1'b1;
        end
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d = S_START;
        end
      end

      S_START: begin
        clk_oe_d = 1'b0;
        state_d  = S_DATA;
      end

      S_DATA: begin
        if (clk_fall_c) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(STOP_I)) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~tx_q[idx_q];
          end
        end
      end

      S_ACK: begin
        if (clk_fall_c) begin
          nack_d  = data_filt_q;
          state_d = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_filt_q && data_filt_q) begin
          done_d  = ~nack_q;
          error_d = nack_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog expiry releases the bus and abandons the transfer.
    if (wd_expire_c) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b1;
      state_d   = S_IDLE;
    end
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin : p_state
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.oPS2_CLK_OE  = clk_oe_q;
  assign bus.oPS2_DATA_OE = data_oe_q;
  assign bus.oBusy        = busy_q;
  assign bus.oDone        = done_q;
  assign bus.oError       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed plus randomized bench for ps2_host_tx with a behavioural PS/2 keyboard on wired-AND lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned IC = 50;
  localparam int unsigned FL = 8;
  localparam int unsigned TO = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic dev_clk;
  logic dev_data;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ps2_host_tx_if bus ();

  // Open-drain bus: either side pulling low wins.
  assign bus.iPS2_CLK  = ~bus.oPS2_CLK_OE & dev_clk;
  assign bus.iPS2_DATA = ~bus.oPS2_DATA_OE & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES (IC),
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits in wire order: d0..d7, odd parity, stop.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  // Issue iSend and check the inhibit/start timing relative to the accept cycle T.
  task automatic host_request(input logic [7:0] b);
    bus.iData = b;
    bus.iSend = 1'b1;
    step(1);
    bus.iSend = 1'b0;
    bus.iData = ~b;
    chk("busy_T1", bus.oBusy, 1);
    chk("clkoe_T1", bus.oPS2_CLK_OE, 1);
    chk("dataoe_T1", bus.oPS2_DATA_OE, 0);
    step(IC - 2);
    chk("dataoe_pre_start", bus.oPS2_DATA_OE, 0);
    chk("clkoe_inhibit", bus.oPS2_CLK_OE, 1);
    step(1);
    chk("dataoe_start", bus.oPS2_DATA_OE, 1);
    step(1);
    chk("clkoe_start", bus.oPS2_CLK_OE, 1);
    step(1);
    chk("clkoe_release", bus.oPS2_CLK_OE, 0);
    chk("dataoe_held", bus.oPS2_DATA_OE, 1);
  endtask

  // mode 0 normal, 1 second iSend mid-frame, 2 clock glitch first, 3 reset after 4th fall.
  task automatic device_frame(input logic [7:0] b, input bit nack, input int half, input int mode);
    logic [9:0] exp;
    logic [9:0] got;
    logic       e;
    logic       prev_busy;
    int         n;
    int         pulses;
    exp       = frame_bits(b);
    got       = '0;
    dev_clk   = 1'b1;
    dev_data  = 1'b1;
    step(half);
    if (mode == 2) begin
      dev_clk = 1'b0;
      step(3);
      dev_clk = 1'b1;
      step(half);
      chk("glitch_no_advance", bus.oPS2_DATA_OE, 1);
    end
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      step(half);
      e = ~exp[k];
      chk($sformatf("oe_bit%0d_%02h", k, b), bus.oPS2_DATA_OE, e);
      if (mode == 3 && k == 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst_clkoe", bus.oPS2_CLK_OE, 0);
        chk("rst_dataoe", bus.oPS2_DATA_OE, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done_err", {bus.oDone, bus.oError}, 0);
        dev_clk = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2);
        return;
      end
      if (mode == 1 && k == 3) begin
        bus.iData = 8'h55;
        bus.iSend = 1'b1;
        step(1);
        bus.iSend = 1'b0;
      end
      dev_clk = 1'b1;
      got[k]  = bus.iPS2_DATA;
      step(half);
    end
    chk($sformatf("frame_%02h", b), got, exp);
    dev_data = nack;
    step(half);
    dev_clk = 1'b0;
    step(half);
    dev_clk = 1'b1;
    step(2);
    dev_data = 1'b1;
    n = 0;
    prev_busy = bus.oBusy;
    while (!(bus.oDone || bus.oError) && n < 200) begin
      prev_busy = bus.oBusy;
      step(1);
      n++;
    end
    chk("end_pulse_seen", bus.oDone | bus.oError, 1);
    chk("busy_before_end", prev_busy, 1);
    chk("busy_fall", bus.oBusy, 0);
    chk("done_val", bus.oDone, !nack);
    chk("error_val", bus.oError, nack);
    pulses = 0;
    repeat (30) begin
      step(1);
      pulses += int'(bus.oDone) + int'(bus.oError) + int'(bus.oBusy);
    end
    chk("no_extra_activity", pulses, 0);
    chk("idle_clkoe", bus.oPS2_CLK_OE, 0);
  endtask

  initial begin
    logic [7:0] b;
    bit         nk;
    int         half;
    rst_n     = 1'b0;
    dev_clk   = 1'b1;
    dev_data  = 1'b1;
    bus.iData = 8'h00;
    bus.iSend = 1'b0;
    step(3);
    chk("reset_clkoe", bus.oPS2_CLK_OE, 0);
    chk("reset_dataoe", bus.oPS2_DATA_OE, 0);
    chk("reset_busy", bus.oBusy, 0);
    chk("reset_done", bus.oDone, 0);
    chk("reset_error", bus.oError, 0);
    rst_n = 1'b1;
    step(2);

    host_request(8'hED);
    device_frame(8'hED, 1'b0, 20, 0);

    host_request(8'h01);
    device_frame(8'h01, 1'b0, 20, 2);

    host_request(8'hFF);
    device_frame(8'hFF, 1'b1, 20, 0);

    host_request(8'hF4);
    device_frame(8'hF4, 1'b0, 20, 1);

    // Reset while the host is inhibiting the clock line.
    bus.iData = 8'h3C;
    bus.iSend = 1'b1;
    step(1);
    bus.iSend = 1'b0;
    step(5);
    chk("inhibit_clkoe", bus.oPS2_CLK_OE, 1);
    rst_n = 1'b0;
    #1;
    chk("inhibit_rst_clkoe", bus.oPS2_CLK_OE, 0);
    chk("inhibit_rst_busy", bus.oBusy, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    host_request(8'hED);
    device_frame(8'hED, 1'b0, 20, 3);
    chk("post_rst_idle", bus.oBusy, 0);
    host_request(8'hED);
    device_frame(8'hED, 1'b0, 20, 0);

`ifdef PS2_TX_TIMEOUT_EN
    // Device never clocks: watchdog fires TO cycles after DATA entry.
    host_request(8'hA5);
    step(TO - 1);
    chk("wd_not_yet", bus.oError, 0);
    chk("wd_busy", bus.oBusy, 1);
    step(1);
    chk("wd_error", bus.oError, 1);
    chk("wd_clkoe", bus.oPS2_CLK_OE, 0);
    chk("wd_dataoe", bus.oPS2_DATA_OE, 0);
    chk("wd_busy_fall", bus.oBusy, 0);
    step(1);
    chk("wd_error_pulse", bus.oError, 0);
    step(5);
`endif

    for (int i = 0; i < 12; i++) begin
      b    = 8'($urandom);
      nk   = ($urandom_range(0, 3) == 0);
      half = int'($urandom_range(14, 30));
      host_request(b);
      device_frame(b, nk, half, 0);
      step(int'($urandom_range(1, 10)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
